// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment display bus as seen by the scan decoder.
// The master side drives segments and digit selects; the slave side hands back the decoded frame.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIG = 4
);
    logic [6:0]           seg;
    logic [NUM_DIG-1:0]   an;
    logic [4*NUM_DIG-1:0] value;
    logic [NUM_DIG-1:0]   blank;
    logic                 err;
    logic                 frame_valid;

    modport master (
        output seg,
        output an,
        input  value,
        input  blank,
        input  err,
        input  frame_valid
    );

    modport slave (
        input  seg,
        input  an,
        output value,
        output blank,
        output err,
        output frame_valid
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from an active-low multiplexed 7-segment bus and
// assembles them into frames with blank and error flags.
module seg7_scan_decoder #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic               clk,
    input  logic               clrn,
    seg7_scan_decoder_if.slave bus
);

    localparam int KW = $clog2(NUM_DIG);
    localparam int CW = $clog2(STABLE_CYC + 1);

    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0]      CNT_MAX  = CW'(STABLE_CYC);
    localparam logic [NUM_DIG-1:0] SEL_ONE  = NUM_DIG'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       bad;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] pat);
        dec_t d;
        d = '{nib: 4'h0, blank: 1'b0, bad: 1'b0};
        case (pat)
            7'b1000000: d.nib = 4'h0;
            7'b1111001: d.nib = 4'h1;
            7'b0100100: d.nib = 4'h2;
            7'b0110000: d.nib = 4'h3;
            7'b0011001: d.nib = 4'h4;
            7'b0010010: d.nib = 4'h5;
            7'b0000010: d.nib = 4'h6;
            7'b1111000: d.nib = 4'h7;
            7'b0000000: d.nib = 4'h8;
            7'b0010000: d.nib = 4'h9;
            7'b0001000: d.nib = 4'hA;
            7'b0000011: d.nib = 4'hB;
            7'b1000110: d.nib = 4'hC;
            7'b0100001: d.nib = 4'hD;
            7'b0000110: d.nib = 4'hE;
            7'b0001110: d.nib = 4'hF;
            7'b1111111: d.blank = 1'b1;
            default:    d.bad = 1'b1;
        endcase
        return d;
    endfunction

    // Two-flop synchronizers: the display bus is driven from another clock domain.
    logic [6:0]         seg_meta_q;
    logic [6:0]         sseg_q;
    logic [NUM_DIG-1:0] an_meta_q;
    logic [NUM_DIG-1:0] san_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            seg_meta_q <= '0;
            sseg_q     <= '0;
            an_meta_q  <= '0;
            san_q      <= '0;
        end else begin
            seg_meta_q <= bus.seg;
            sseg_q     <= seg_meta_q;
            an_meta_q  <= bus.an;
            san_q      <= an_meta_q;
        end
    end

    logic [NUM_DIG-1:0] sel_zeros;
    logic               sel_valid;
    logic [KW-1:0]      sel_idx;

    // A select is usable only when exactly one line is pulled low.
    always_comb begin
        sel_zeros = ~san_q;
        sel_valid = (sel_zeros != '0) && ((sel_zeros & (sel_zeros - SEL_ONE)) == '0);
        sel_idx   = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (sel_zeros[i]) begin
                sel_idx = KW'(i);
            end
        end
    end

    dec_t dec;
    assign dec = decode(sseg_q);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [6:0]    lseg_q, lseg_d;
    logic          cap;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            lseg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            lseg_q  <= lseg_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        lseg_d  = lseg_q;
        cap     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_valid) begin
                    cnt_d   = CNT_ONE;
                    k_d     = sel_idx;
                    lseg_d  = sseg_q;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (!sel_valid) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sel_idx != k_q || sseg_q != lseg_q) begin
                    cnt_d  = CNT_ONE;
                    k_d    = sel_idx;
                    lseg_d = sseg_q;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_MAX;
                    cap     = 1'b1;
                    state_d = CAPTURED;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            CAPTURED: begin
                if (!sel_valid) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sel_idx != k_q || sseg_q != lseg_q) begin
                    cnt_d   = CNT_ONE;
                    k_d     = sel_idx;
                    lseg_d  = sseg_q;
                    state_d = SETTLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    logic [3:0]           hold_nib_q [NUM_DIG];
    logic [NUM_DIG-1:0]   hold_blank_q;
    logic [NUM_DIG-1:0]   hold_bad_q;
    logic [NUM_DIG-1:0]   mask_q, mask_d;
    logic [4*NUM_DIG-1:0] hold_value;
    logic                 frame_done;

    assign frame_done = &mask_q;

    // A capture on the completion edge re-arms its own mask bit after the clear.
    always_comb begin
        mask_d = mask_q;
        if (frame_done) begin
            mask_d = '0;
        end
        if (cap) begin
            mask_d[k_q] = 1'b1;
        end
    end

    always_comb begin
        hold_value = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            hold_value[4*i +: 4] = hold_nib_q[i];
        end
    end

    // NOTE: the holding slots are reset explicitly so a reset mid-frame cannot leak old digits.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                hold_nib_q[i] <= '0;
            end
            hold_blank_q <= '0;
            hold_bad_q   <= '0;
            mask_q       <= '0;
        end else begin
            mask_q <= mask_d;
            if (cap) begin
                hold_nib_q[k_q]   <= dec.nib;
                hold_blank_q[k_q] <= dec.blank;
                hold_bad_q[k_q]   <= dec.bad;
            end
        end
    end

    logic [4*NUM_DIG-1:0] value_q;
    logic [NUM_DIG-1:0]   blank_q;
    logic                 err_q;
    logic                 fv_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            value_q <= '0;
            blank_q <= '0;
            err_q   <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            fv_q <= frame_done;
            if (frame_done) begin
                value_q <= hold_value;
                blank_q <= hold_blank_q;
                err_q   <= |hold_bad_q;
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.blank       = blank_q;
    assign bus.err         = err_q;
    assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues expected frames,
// a negedge monitor pops and compares them whenever frame_valid is seen.
module tb_seg7_scan_decoder;

    localparam int NUM_DIG    = 4;
    localparam int STABLE_CYC = 4;

    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0]  BLANK   = 7'b1111111;
    localparam logic [6:0]  BADPAT  = 7'b1010101;
    localparam logic [15:0] SEQ_EXP [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NUM_DIG(NUM_DIG)) dut_if ();

    seg7_scan_decoder #(
        .NUM_DIG    (NUM_DIG),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (dut_if)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   frames_seen = 0;
    logic fv_prev     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] v, input logic [3:0] b, input logic e);
        exp_t x;
        x.value = v;
        x.blank = b;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    task automatic drive_raw(input logic [3:0] a, input logic [6:0] s, input int n);
        dut_if.an  = a;
        dut_if.seg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int dig, input logic [6:0] s, input int n);
        drive_raw(~(NUM_DIG'(1) << dig), s, n);
    endtask

    // Monitor: compares each presented frame with the oldest queued expectation.
    always @(negedge clk) begin
        if (clrn && dut_if.frame_valid) begin
            frames_seen++;
            check("fv_single_cycle", 32'(fv_prev), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame: got value 0x%0h, expected no frame at %0t",
                         dut_if.value, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_value", 32'(dut_if.value), 32'(mon_e.value));
                check("frame_blank", 32'(dut_if.blank), 32'(mon_e.blank));
                check("frame_err",   32'(dut_if.err),   32'(mon_e.err));
            end
        end
        fv_prev <= dut_if.frame_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clrn       = 1'b0;
        dut_if.seg = BLANK;
        dut_if.an  = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(dut_if.value), 32'd0);
        check("reset_blank", 32'(dut_if.blank), 32'd0);
        check("reset_err",   32'(dut_if.err),   32'd0);
        check("reset_fv",    32'(dut_if.frame_valid), 32'd0);
        clrn = 1'b1;
        drive_raw('1, BLANK, 2);

        // Basic frame: digits 0..3 show 4,3,2,1.
        push_exp(16'h1234, 4'b0000, 1'b0);
        drive(0, PAT[4], 10);
        drive(1, PAT[3], 10);
        drive(2, PAT[2], 10);
        drive(3, PAT[1], 10);

        // All sixteen table patterns over four frames.
        for (int f = 0; f < 4; f++) begin
            push_exp(SEQ_EXP[f], 4'b0000, 1'b0);
            for (int d = 0; d < 4; d++) begin
                drive(d, PAT[4*f + d], 10);
            end
        end

        // Dark digit 1.
        push_exp(16'h8705, 4'b0010, 1'b0);
        drive(0, PAT[5], 10);
        drive(1, BLANK,  10);
        drive(2, PAT[7], 10);
        drive(3, PAT[8], 10);

        // Undecodable pattern on digit 2, then a clean frame.
        push_exp(16'hB0A9, 4'b0000, 1'b1);
        drive(0, PAT[9],  10);
        drive(1, PAT[10], 10);
        drive(2, BADPAT,  10);
        drive(3, PAT[11], 10);
        push_exp(16'hCDEF, 4'b0000, 1'b0);
        drive(0, PAT[15], 10);
        drive(1, PAT[14], 10);
        drive(2, PAT[13], 10);
        drive(3, PAT[12], 10);

        // Digit 3 held 3 cycles is too short; later held exactly 4 it captures.
        push_exp(16'h6325, 4'b0000, 1'b0);
        drive(0, PAT[1], 10);
        drive(1, PAT[2], 10);
        drive(2, PAT[3], 10);
        drive(3, PAT[4], 3);
        drive(0, PAT[5], 10);
        check("no_frame_short_hold", 32'(frames_seen), 32'd8);
        drive(3, PAT[6], 4);

        // Segment glitch on digit 0 restarts the stability count.
        push_exp(16'h1097, 4'b0000, 1'b0);
        drive(0, PAT[7], 2);
        drive(0, PAT[8], 1);
        drive(0, PAT[7], 4);
        drive(1, PAT[9], 10);
        drive(2, PAT[0], 10);
        drive(3, PAT[1], 10);

        // Invalid selects: nothing captured, outputs hold.
        drive_raw(4'b1111, PAT[2], 20);
        drive_raw(4'b1100, PAT[2], 20);
        check("idle_frames",     32'(frames_seen),  32'd10);
        check("idle_hold_value", 32'(dut_if.value), 32'h1097);
        check("idle_hold_blank", 32'(dut_if.blank), 32'd0);
        check("idle_hold_err",   32'(dut_if.err),   32'd0);

        push_exp(16'h4321, 4'b0000, 1'b0);
        drive(0, PAT[1], 10);
        drive(1, PAT[2], 10);
        drive(2, PAT[3], 10);
        drive(3, PAT[4], 10);

        // Reset after three of four digits captured.
        drive(0, PAT[10], 10);
        drive(1, PAT[11], 10);
        drive(2, PAT[12], 10);
        drive_raw('1, BLANK, 2);
        check("pre_reset_frames", 32'(frames_seen), 32'd11);
        clrn = 1'b0;
        #1;
        check("midreset_value", 32'(dut_if.value), 32'd0);
        check("midreset_blank", 32'(dut_if.blank), 32'd0);
        check("midreset_err",   32'(dut_if.err),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        drive_raw('1, BLANK, 2);

        // Post-reset scan starting on digit 3 so stale mask bits would fire early.
        push_exp(16'h2765, 4'b0000, 1'b0);
        drive(3, PAT[2], 10);
        drive(0, PAT[5], 10);
        drive(1, PAT[6], 10);
        drive(2, PAT[7], 10);
        drive_raw('1, BLANK, 10);

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        check("total_frames",   32'(frames_seen),  32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
